// File: rtl/handshake_energy_monitor.sv
// handshake_energy_monitor: passive observer of NB_PORTS valid/ready channels.
// Accumulates an energy figure per handshake (full word width or Hamming
// toggle count against the port's previous word), counts transfers per port
// and counts measuring cycles over a start/stop or fixed-length window.
// All counters saturate at all-ones and raise a sticky overflow flag.
module handshake_energy_monitor #(
  parameter int unsigned NB_PORTS     = 3,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned CNT_WIDTH    = 48,
  parameter int unsigned XFER_WIDTH   = 32,
  parameter int unsigned WINDOW_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           arst_n,
  input  logic                           start,
  input  logic                           stop,
  input  logic                           mode,
  input  logic [WINDOW_WIDTH-1:0]        window_len,
  input  logic [NB_PORTS-1:0]            valid,
  input  logic [NB_PORTS-1:0]            ready,
  input  logic [NB_PORTS*DATA_WIDTH-1:0] data,
  output logic                           running,
  output logic                           done,
  output logic [CNT_WIDTH-1:0]           energy_total,
  output logic [NB_PORTS*XFER_WIDTH-1:0] xfer_count,
  output logic [WINDOW_WIDTH-1:0]        cycle_count,
  output logic                           overflow
);

  // Width of one port's cost (0..DATA_WIDTH) and of the per-cycle cost sum.
  localparam int unsigned COST_W = $clog2(DATA_WIDTH + 1);
  localparam int unsigned SUM_W  = $clog2(NB_PORTS * DATA_WIDTH + 1);
  // Adder is one bit wider than the larger operand so a clamp is detectable.
  localparam int unsigned ADD_W  = ((CNT_WIDTH > SUM_W) ? CNT_WIDTH : SUM_W) + 1;
  localparam logic [ADD_W-1:0] ENERGY_MAX = ADD_W'({CNT_WIDTH{1'b1}});

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEAS = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  logic                    r_mode;
  logic [WINDOW_WIDTH-1:0] r_window;
  logic [DATA_WIDTH-1:0]   r_prev   [NB_PORTS];
  logic [XFER_WIDTH-1:0]   r_xfer   [NB_PORTS];
  logic [CNT_WIDTH-1:0]    r_energy;
  logic [WINDOW_WIDTH-1:0] r_cycle;
  logic                    r_running;
  logic                    r_done;
  logic                    r_overflow;

  logic [NB_PORTS-1:0]     w_fire;
  logic [NB_PORTS-1:0]     w_xfer_sat;
  logic [COST_W-1:0]       w_cost   [NB_PORTS];
  logic [SUM_W-1:0]        w_cost_sum;
  logic [ADD_W-1:0]        w_energy_wide;
  logic                    w_energy_clamp;
  logic [CNT_WIDTH-1:0]    w_energy_nxt;
  logic                    w_cycle_sat;
  logic [WINDOW_WIDTH-1:0] w_cycle_inc;
  logic                    w_win_hit;
  logic                    w_end;
  logic                    w_clamp;

  assign w_fire = valid & ready;

  // Per-port cost, saturation detect and packed output view.
  for (genvar gp = 0; gp < int'(NB_PORTS); gp++) begin : g_port
    logic [DATA_WIDTH-1:0] w_word;
    logic [DATA_WIDTH-1:0] w_diff;
    logic [COST_W-1:0]     w_pop;

    assign w_word = data[gp*DATA_WIDTH +: DATA_WIDTH];
    assign w_diff = w_word ^ r_prev[gp];

    // Hamming distance between this word and the port's previous word.
    always_comb begin
      w_pop = '0;
      for (int b = 0; b < int'(DATA_WIDTH); b++) begin
        w_pop = w_pop + COST_W'(w_diff[b]);
      end
    end

    assign w_cost[gp]     = r_mode ? w_pop : COST_W'(DATA_WIDTH);
    assign w_xfer_sat[gp] = &r_xfer[gp];
    assign xfer_count[gp*XFER_WIDTH +: XFER_WIDTH] = r_xfer[gp];
  end

  // Sum the costs of every port firing this cycle.
  always_comb begin
    w_cost_sum = '0;
    for (int p = 0; p < int'(NB_PORTS); p++) begin
      if (w_fire[p]) begin
        w_cost_sum = w_cost_sum + SUM_W'(w_cost[p]);
      end
    end
  end

  // Saturating energy accumulation.
  assign w_energy_wide  = ADD_W'(r_energy) + ADD_W'(w_cost_sum);
  assign w_energy_clamp = (w_energy_wide > ENERGY_MAX);
  assign w_energy_nxt   = w_energy_clamp ? {CNT_WIDTH{1'b1}}
                                         : w_energy_wide[CNT_WIDTH-1:0];

  // Window expiry: the cycle being counted now is the last one of the window.
  assign w_cycle_sat = &r_cycle;
  assign w_cycle_inc = r_cycle + WINDOW_WIDTH'(1);
  assign w_win_hit   = (r_window != '0) && (w_cycle_inc == r_window);
  assign w_end       = stop | w_win_hit;

  // Any counter that would pass all-ones this cycle.
  assign w_clamp = w_energy_clamp | (|(w_fire & w_xfer_sat)) | w_cycle_sat;

  // Measurement FSM with all counters and status flags.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state    <= ST_IDLE;
      r_mode     <= 1'b0;
      r_window   <= '0;
      r_energy   <= '0;
      r_cycle    <= '0;
      r_running  <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      for (int p = 0; p < int'(NB_PORTS); p++) begin
        r_prev[p] <= '0;
        r_xfer[p] <= '0;
      end
    end else if (start) begin
      // Start (or restart) wins over stop and expiry; start-cycle fires are dropped.
      r_state    <= ST_MEAS;
      r_mode     <= mode;
      r_window   <= window_len;
      r_energy   <= '0;
      r_cycle    <= '0;
      r_running  <= 1'b1;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      for (int p = 0; p < int'(NB_PORTS); p++) begin
        r_prev[p] <= '0;
        r_xfer[p] <= '0;
      end
    end else begin
      case (r_state)
        ST_MEAS: begin
          if (!w_cycle_sat) begin
            r_cycle <= w_cycle_inc;
          end
          r_energy   <= w_energy_nxt;
          r_overflow <= r_overflow | w_clamp;
          for (int p = 0; p < int'(NB_PORTS); p++) begin
            if (w_fire[p]) begin
              if (!w_xfer_sat[p]) begin
                r_xfer[p] <= r_xfer[p] + XFER_WIDTH'(1);
              end
              r_prev[p] <= data[p*DATA_WIDTH +: DATA_WIDTH];
            end
          end
          if (w_end) begin
            r_state   <= ST_DONE;
            r_running <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE hold every counter frozen.
          r_state <= r_state;
        end
      endcase
    end
  end

  assign running      = r_running;
  assign done         = r_done;
  assign energy_total = r_energy;
  assign cycle_count  = r_cycle;
  assign overflow     = r_overflow;

endmodule

// File: doc/handshake_energy_monitor.md
Name: handshake_energy_monitor

Overview:
- Synthesizable, parametrised successor to the testbench-side bit-transfer energy estimate.
- Watches NB_PORTS valid/ready channels and accumulates an energy figure for each handshake: either full word width, or the Hamming toggle count against that port's previously transferred word.
- Counts transfers per port over a start/stop or fixed-length measurement window.
- Sits beside the accelerator top level; passive, never drives valid/ready.

Parameters:
- NB_PORTS, 3, number of monitored handshake channels.
- DATA_WIDTH, 16, data bits per channel word.
- CNT_WIDTH, 48, width of energy_total accumulator.
- XFER_WIDTH, 32, width of each per-port transfer counter.
- WINDOW_WIDTH, 32, width of window_len and cycle_count.

Ports:
- clk  in  1  clock; single clock domain.
- arst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; clears counters and begins a measurement.
- stop  in  1  pulse; ends the measurement.
- mode  in  1  0 = word cost (DATA_WIDTH per transfer), 1 = toggle cost (popcount of data XOR previous word on that port); sampled on start.
- window_len  in  WINDOW_WIDTH  0 = unbounded; else auto-stop after this many measuring cycles; sampled on start.
- valid  in  NB_PORTS  per-port valid.
- ready  in  NB_PORTS  per-port ready; output channels tie ready high.
- data  in  NB_PORTS*DATA_WIDTH  per-port word; port p occupies bits [p*DATA_WIDTH +: DATA_WIDTH].
- running  out  1  high while measuring.
- done  out  1  high from measurement end until next start.
- energy_total  out  CNT_WIDTH  accumulated cost.
- xfer_count  out  NB_PORTS*XFER_WIDTH  per-port transfer count, packed like data.
- cycle_count  out  WINDOW_WIDTH  measuring cycles elapsed.
- overflow  out  1  sticky; set when any counter saturates.

Behaviour:
- Reset (async assert, sync deassert, no other gating): all outputs 0, state IDLE, mode_q = 0, window_q = 0, prev_data[p] = 0.
- fire[p] = valid[p] & ready[p]. No protocol checking.
- States are IDLE, MEAS, DONE.
- IDLE/DONE + start -> MEAS:
  - clear energy_total, xfer_count, cycle_count, overflow, prev_data; done = 0.
  - latch mode and window_len.
  - fires in the start cycle are not counted; running rises the next cycle.
- MEAS, each cycle:
  - cycle_count += 1.
  - for each fire[p]: xfer_count[p] += 1; cost_p = DATA_WIDTH (mode_q = 0) or popcount(data_p ^ prev_data[p]) (mode_q = 1); then prev_data[p] <= data_p.
  - energy_total += sum of cost_p over all firing ports, same cycle, single adder tree.
- MEAS -> DONE when stop = 1, or when window_q != 0 and cycle_count + 1 == window_q.
  - the transition cycle's fires and cycle increment are still counted.
  - running falls and done rises on the next edge.
- start in MEAS restarts: same as the IDLE + start path. start has priority over stop and window expiry in the same cycle.
- stop in IDLE/DONE: ignored.
- Latency: outputs are registered; a fire at cycle t is visible at cycle t+1.
- Saturation: every counter clamps at all-ones. The first clamp sets overflow, which holds until the next start or reset.
- Toggle mode: the first transfer on each port after start compares against 0 (prev_data cleared at start).
- Counters are readable at any time; they are frozen in IDLE and DONE.
- arst_n asserted mid-measurement aborts to IDLE with all values zeroed and no done pulse.

Test Plan:
- Word mode, NB_PORTS = 3, DATA_WIDTH = 16, window_len = 0: start; fire port0 5 times, port1 3 times, port2 every cycle for 10 cycles; stop -> energy_total = 288, xfer_count = {10,3,5}, done = 1, running = 0 one cycle after stop.
- Toggle mode: port0 transfers 0x0000, 0xFFFF, 0xFFFF, 0x00FF -> energy_total = 0 + 16 + 0 + 8 = 24, xfer_count[0] = 4.
- window_len = 8, port1 fires every cycle, no stop: running for exactly 8 cycles -> cycle_count = 8, xfer_count[1] = 8, energy_total = 128, done asserts automatically.
- Simultaneous events and stall: start and stop in the same cycle while MEAS -> restart, counters zero, running stays 1. Valid high with ready low for 4 cycles -> no count change.
- Saturation at CNT_WIDTH = 8, word mode, DATA_WIDTH = 16: 20 transfers -> energy_total = 255, overflow = 1 until the next start.
- Reset mid-measurement: arst_n low for 1 cycle after 5 transfers -> all outputs 0, state IDLE, next start counts from zero.
